// File: rtl/rom_loader.sv
// rom_loader: packs the HPS ioctl byte stream into 16-bit LE words for the cart-ROM controller.
// Build option ROM_LOADER_CHECKSUM_EN enables the 16-bit additive checksum on rom_sum.
module rom_loader #(
  parameter int         MEM_AW    = 23,
  parameter logic [7:0] ROM_INDEX = 8'h00,
  parameter int         HDR_BYTES = 512
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              mem_req,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [15:0]       mem_din,
  input  logic              mem_ack,
  output logic [24:0]       rom_size,
  output logic              rom_hdr,
  output logic              rom_ready,
  output logic [15:0]       rom_sum
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_FLUSH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  logic [2:0]        state_q, state_d;
  logic              active_q;
  logic [7:0]        low_q, low_d;
  logic              low_vld_q, low_vld_d;
  logic [MEM_AW-1:0] low_addr_q, low_addr_d;
  logic [7:0]        skid_data_q, skid_data_d;
  logic [24:0]       skid_addr_q, skid_addr_d;
  logic              skid_vld_q, skid_vld_d;
  logic              ovf_q, ovf_d;
  logic [24:0]       byte_cnt_q, byte_cnt_d;
  logic              req_q, req_d;
  logic              wait_q, wait_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [15:0]       din_q, din_d;
  logic [24:0]       size_q, size_d;
  logic              hdr_q, hdr_d;
  logic              ready_q, ready_d;

  logic        active_s, start_s, wr_acc_s, src_vld_s;
  logic [24:0] cnt_next_s, src_addr_s;
  logic [7:0]  src_data_s;

  assign active_s   = ioctl_download & (ioctl_index == ROM_INDEX);
  assign start_s    = (state_q == ST_IDLE) & active_s & ~active_q;
  assign wr_acc_s   = active_s & ioctl_wr & ((state_q == ST_LOAD) | (state_q == ST_WRITE));
  assign cnt_next_s = ioctl_addr + 25'd1;

  // A pending skid byte is older than any live byte, so it is consumed first.
  assign src_vld_s  = skid_vld_q | wr_acc_s;
  assign src_data_s = skid_vld_q ? skid_data_q : ioctl_dout;
  assign src_addr_s = skid_vld_q ? skid_addr_q : ioctl_addr;

  always_comb begin
    state_d     = state_q;
    low_d       = low_q;
    low_vld_d   = low_vld_q;
    low_addr_d  = low_addr_q;
    skid_data_d = skid_data_q;
    skid_addr_d = skid_addr_q;
    skid_vld_d  = skid_vld_q;
    ovf_d       = ovf_q;
    req_d       = req_q;
    wait_d      = wait_q;
    addr_d      = addr_q;
    din_d       = din_q;
    size_d      = size_q;
    hdr_d       = hdr_q;
    ready_d     = ready_q;
    byte_cnt_d  = (wr_acc_s && (cnt_next_s > byte_cnt_q)) ? cnt_next_s : byte_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          ready_d    = 1'b0;
          size_d     = 25'd0;
          hdr_d      = 1'b0;
          low_d      = 8'h00;
          low_vld_d  = 1'b0;
          skid_vld_d = 1'b0;
          ovf_d      = 1'b0;
          byte_cnt_d = 25'd0;
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // A live byte arriving while the skid byte is consumed takes its place.
        skid_vld_d  = skid_vld_q & wr_acc_s;
        skid_data_d = ioctl_dout;
        skid_addr_d = ioctl_addr;
        if (src_vld_s) begin
          if (src_addr_s[0] == 1'b0) begin
            low_d      = src_data_s;
            low_vld_d  = 1'b1;
            low_addr_d = src_addr_s[MEM_AW:1];
          end else begin
            addr_d    = src_addr_s[MEM_AW:1];
            din_d     = {src_data_s, (low_vld_q ? low_q : 8'hFF)};
            low_vld_d = 1'b0;
            req_d     = 1'b1;
            wait_d    = 1'b1;
            state_d   = ST_WRITE;
          end
        end else if (!active_s) begin
          if (low_vld_q) begin
            addr_d  = low_addr_q;
            din_d   = {8'hFF, low_q};
            req_d   = 1'b1;
            wait_d  = 1'b1;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (wr_acc_s) begin
          skid_data_d = ioctl_dout;
          skid_addr_d = ioctl_addr;
          skid_vld_d  = 1'b1;
          ovf_d       = ovf_q | skid_vld_q;
        end else begin
          skid_vld_d = skid_vld_q;
        end
        if (mem_ack) begin
          req_d   = 1'b0;
          wait_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_FLUSH: begin
        if (mem_ack) begin
          req_d     = 1'b0;
          wait_d    = 1'b0;
          low_vld_d = 1'b0;
          state_d   = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        size_d  = byte_cnt_q;
        hdr_d   = (byte_cnt_q[12:0] == 13'(HDR_BYTES));
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      active_q    <= 1'b0;
      low_q       <= 8'h00;
      low_vld_q   <= 1'b0;
      low_addr_q  <= '0;
      skid_data_q <= 8'h00;
      skid_addr_q <= 25'd0;
      skid_vld_q  <= 1'b0;
      ovf_q       <= 1'b0;
      byte_cnt_q  <= 25'd0;
      req_q       <= 1'b0;
      wait_q      <= 1'b0;
      addr_q      <= '0;
      din_q       <= 16'h0000;
      size_q      <= 25'd0;
      hdr_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_s;
      low_q       <= low_d;
      low_vld_q   <= low_vld_d;
      low_addr_q  <= low_addr_d;
      skid_data_q <= skid_data_d;
      skid_addr_q <= skid_addr_d;
      skid_vld_q  <= skid_vld_d;
      ovf_q       <= ovf_d;
      byte_cnt_q  <= byte_cnt_d;
      req_q       <= req_d;
      wait_q      <= wait_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      size_q      <= size_d;
      hdr_q       <= hdr_d;
      ready_q     <= ready_d;
    end
  end

  assign ioctl_wait = wait_q;
  assign mem_req    = req_q;
  assign mem_addr   = addr_q;
  assign mem_din    = din_q;
  assign rom_size   = size_q;
  assign rom_hdr    = hdr_q;
  assign rom_ready  = ready_q;

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  assign sum_d = start_s ? 16'h0000 : (wr_acc_s ? (sum_q + {8'h00, ioctl_dout}) : sum_q);

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      sum_q <= 16'h0000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign rom_sum = sum_q;
`else
  assign rom_sum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed downloads against a scoreboard of expected memory words
// and a memory-controller model with programmable ack latency.
module tb_rom_loader;
  localparam int MEM_AW = 23;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic              ioctl_wait;
  logic              mem_req;
  logic [MEM_AW-1:0] mem_addr;
  logic [15:0]       mem_din;
  logic              mem_ack = 1'b0;
  logic [24:0]       rom_size;
  logic              rom_hdr;
  logic              rom_ready;
  logic [15:0]       rom_sum;

  int   n_cmp = 0;
  int   n_err = 0;
  int   ack_delay = 2;
  logic resp_busy = 1'b0;

  logic [MEM_AW+15:0] sb_q[$];
  logic [7:0]         bytes_q[$];

  rom_loader #(.MEM_AW(MEM_AW)) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_ack        (mem_ack),
    .rom_size       (rom_size),
    .rom_hdr        (rom_hdr),
    .rom_ready      (rom_ready),
    .rom_sum        (rom_sum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory controller: pops the scoreboard on each new request, acks after ack_delay cycles.
  always begin : mem_model
    logic [MEM_AW+15:0] got_w;
    logic [MEM_AW+15:0] exp_w;
    @(negedge clk_sys);
    if (mem_req === 1'b1) begin
      resp_busy = 1'b1;
      got_w = {mem_addr, mem_din};
      check("sb_nonempty", 64'(sb_q.size() > 0), 64'd1);
      check("wait_on_req", 64'(ioctl_wait), 64'd1);
      if (sb_q.size() > 0) begin
        exp_w = sb_q.pop_front();
        check("mem_write", 64'(got_w), 64'(exp_w));
      end
      for (int i = 1; i < ack_delay; i++) begin
        @(negedge clk_sys);
        if (mem_req === 1'b1) begin
          check("req_hold", 64'({mem_addr, mem_din}), 64'(got_w));
          check("wait_hold", 64'(ioctl_wait), 64'd1);
        end
      end
      mem_ack = 1'b1;
      @(negedge clk_sys);
      mem_ack = 1'b0;
      resp_busy = 1'b0;
    end
  end

  task automatic push_expected();
    logic [7:0] hi;
    for (int i = 0; i < bytes_q.size(); i += 2) begin
      hi = (i + 1 < bytes_q.size()) ? bytes_q[i+1] : 8'hFF;
      sb_q.push_back({MEM_AW'(i / 2), hi, bytes_q[i]});
    end
  endtask

  task automatic hps_byte(input logic [24:0] a, input logic [7:0] d, input bit honour_wait);
    int guard = 0;
    while (honour_wait && (ioctl_wait === 1'b1) && (guard < 200)) begin
      @(negedge clk_sys);
      guard++;
    end
    if (guard >= 200) check("wait_timeout", 64'(guard), 64'd0);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    @(negedge clk_sys);
    ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic load_file(input logic [7:0] idx);
    start_dl(idx);
    foreach (bytes_q[i]) hps_byte(25'(i), bytes_q[i], 1'b1);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
  endtask

  task automatic check_done(input logic [24:0] exp_size, input logic exp_hdr);
    int guard = 0;
    logic [15:0] s = 16'h0000;
`ifdef ROM_LOADER_CHECKSUM_EN
    foreach (bytes_q[i]) s = s + 16'(bytes_q[i]);
`endif
    while ((rom_ready !== 1'b1) && (guard < 300)) begin
      @(negedge clk_sys);
      guard++;
    end
    check("ready_rise", 64'(guard < 300), 64'd1);
    check("rom_size", 64'(rom_size), 64'(exp_size));
    check("rom_hdr", 64'(rom_hdr), 64'(exp_hdr));
    check("rom_sum", 64'(rom_sum), 64'(s));
    check("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    int guard;
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'h00;
    ioctl_wr = 1'b0; ioctl_addr = 25'd0; ioctl_dout = 8'h00;
    repeat (3) @(negedge clk_sys);
    check("rst_req", 64'(mem_req), 64'd0);
    check("rst_wait", 64'(ioctl_wait), 64'd0);
    check("rst_addr_din", 64'({mem_addr, mem_din}), 64'd0);
    check("rst_rom", 64'({rom_size, rom_hdr, rom_ready}), 64'd0);
    check("rst_sum", 64'(rom_sum), 64'd0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    // 4 bytes, ack 2 cycles after each request
    ack_delay = 2;
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_expected();
    load_file(8'h00);
    check_done(25'd4, 1'b0);

    // odd length: last word comes from the flush path
    bytes_q = '{8'hAA, 8'hBB, 8'hCC};
    push_expected();
    load_file(8'h00);
    check_done(25'd3, 1'b0);

    // long ack stall with one byte pushed past ioctl_wait into the skid register
    ack_delay = 10;
    bytes_q = '{8'h10, 8'h20, 8'h30, 8'h40};
    push_expected();
    start_dl(8'h00);
    hps_byte(25'd0, 8'h10, 1'b1);
    hps_byte(25'd1, 8'h20, 1'b1);
    check("wait_in_write", 64'(ioctl_wait), 64'd1);
    hps_byte(25'd2, 8'h30, 1'b0);
    hps_byte(25'd3, 8'h40, 1'b1);
    @(negedge clk_sys);
    ioctl_download = 1'b0;
    check_done(25'd4, 1'b0);
    check("ovf", 64'(dut.ovf_q), 64'd0);

    // 8192+512 bytes carries a copier header, 8192 does not
    ack_delay = 1;
    bytes_q.delete();
    for (int i = 0; i < 8704; i++) bytes_q.push_back(8'(i * 7 + 3));
    push_expected();
    load_file(8'h00);
    check_done(25'd8704, 1'b1);
    bytes_q.delete();
    for (int i = 0; i < 8192; i++) bytes_q.push_back(8'(i * 13 + 1));
    push_expected();
    load_file(8'h00);
    check_done(25'd8192, 1'b0);

    // foreign index is ignored entirely
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_file(8'h01);
    repeat (20) @(negedge clk_sys);
    check("idx1_ready", 64'(rom_ready), 64'd1);
    check("idx1_size", 64'(rom_size), 64'd8192);
    check("idx1_sb", 64'(sb_q.size()), 64'd0);

    // zero-byte download
    ack_delay = 2;
    bytes_q.delete();
    load_file(8'h00);
    check_done(25'd0, 1'b0);

    // reset while a write is outstanding, then a clean download
    ack_delay = 20;
    bytes_q = '{8'h5A, 8'hA5};
    push_expected();
    start_dl(8'h00);
    hps_byte(25'd0, 8'h5A, 1'b1);
    hps_byte(25'd1, 8'hA5, 1'b1);
    check("req_before_rst", 64'(mem_req), 64'd1);
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    @(negedge clk_sys);
    check("rst_mid_req", 64'(mem_req), 64'd0);
    check("rst_mid_wait", 64'(ioctl_wait), 64'd0);
    check("rst_mid_ready", 64'(rom_ready), 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'd0);
    reset_n = 1'b1;
    guard = 0;
    while ((resp_busy === 1'b1) && (guard < 100)) begin
      @(negedge clk_sys);
      guard++;
    end
    check("resp_idle", 64'(guard < 100), 64'd1);
    ack_delay = 2;
    bytes_q = '{8'h01, 8'h02};
    push_expected();
    load_file(8'h00);
    check_done(25'd2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Sits directly downstream of the HPS download port (ioctl_* bus).
- Packs the byte stream into 16-bit little-endian words and writes them to the cart-ROM memory controller through a req/ack handshake. Back-pressures the HPS with ioctl_wait.
- At end of download, publishes ROM size and the 512-byte copier-header flag for the mapper.

Parameters:
- MEM_AW, 23, memory word-address width (address covers 2^MEM_AW words).
- ROM_INDEX, 8'h00, ioctl_index value accepted; any other index is ignored.
- HDR_BYTES, 512, copier-header size checked at end of download.

Ports:
- clk_sys  in  1  system clock, all logic posedge.
- reset_n  in  1  synchronous active-low reset.
- ioctl_download  in  1  download active (level).
- ioctl_index  in  8  menu index of the file.
- ioctl_wr  in  1  one-cycle byte strobe.
- ioctl_addr  in  25  byte address of ioctl_dout.
- ioctl_dout  in  8  download byte.
- ioctl_wait  out  1  back-pressure to the HPS.
- mem_req  out  1  write request, level, held until ack.
- mem_addr  out  MEM_AW  word address.
- mem_din  out  16  write word, {odd byte, even byte}.
- mem_ack  in  1  one-cycle acknowledge from the memory controller.
- rom_size  out  25  byte count of the last completed download.
- rom_hdr  out  1  1 = file carries a HDR_BYTES copier header.
- rom_ready  out  1  ROM valid, for releasing core reset.
- rom_sum  out  16  additive checksum (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at a clk_sys edge): state IDLE; all outputs 0; skid register empty. Reset mid-write drops mem_req immediately and discards the partial word.
- active = ioctl_download & (ioctl_index==ROM_INDEX). Bytes with ioctl_wr while not active are ignored.
- IDLE:
  - On rising edge of active: clear rom_ready, rom_size, rom_hdr, rom_sum and the low-byte latch; go to LOAD.
- LOAD:
  - ioctl_wr with ioctl_addr[0]=0: latch the low byte.
  - ioctl_wr with ioctl_addr[0]=1: form mem_din={ioctl_dout, low}, mem_addr=ioctl_addr[MEM_AW:1]; next cycle mem_req=1, go to WRITE.
  - A high byte with no preceding low byte uses low=8'hFF.
  - Every accepted byte updates byte_cnt = max(byte_cnt, ioctl_addr+1).
- WRITE:
  - ioctl_wait=1 (registered, asserted the same cycle mem_req rises).
  - mem_req, mem_addr and mem_din are held stable until mem_ack.
  - On mem_ack: mem_req=0; return to LOAD (or FLUSH/DONE if download has ended).
  - One ioctl_wr arriving while in WRITE is stored in a 1-byte skid register with its addr bit0 and consumed on the return to LOAD. Latency is one extra cycle, no byte loss.
  - A second byte while the skid register is full is a protocol violation: it overwrites the skid register and sets the internal sticky flag ovf (visible in simulation only).
  - mem_ack while mem_req=0 is ignored.
- Falling edge of active:
  - If an even byte is latched but unpaired: go to FLUSH. Write {8'hFF, low} at that word address with the same req/ack rules.
  - Then go to DONE.
  - If a WRITE is in flight, finish it (and any pending skid byte) first.
- DONE:
  - rom_size=byte_cnt.
  - rom_hdr = (byte_cnt[12:0]==HDR_BYTES).
  - rom_ready=1 one cycle after entering DONE; rom_ready remains high until the next accepted download starts.
  - Next cycle: go to IDLE.
- ioctl_wait=0 in IDLE, LOAD and DONE.
- A zero-byte download yields rom_size=0, rom_hdr=0, rom_ready=1, with no memory writes.
- Address wrap: ioctl_addr bits above MEM_AW are dropped (aliasing), not an error.

Optional Feature:
- ROM_LOADER_CHECKSUM_EN.
  - Defined: rom_sum = 16-bit wrap-around sum of all accepted bytes, zero-extended, header bytes included. Cleared at download start; final value is valid when rom_ready rises.
  - Undefined: rom_sum is tied to 16'h0000 and no adder is synthesised.

Test Plan:
- 4-byte download at index 0 (addr 0..3, data 11 22 33 44), mem_ack 2 cycles after each req -> writes {addr 0: 16'h2211}, {addr 1: 16'h4433}; rom_size=4, rom_hdr=0, rom_ready=1; rom_sum=16'h00AA with CHECKSUM_EN.
- 3-byte download (AA BB CC) -> second write is {addr 1: 16'hFFCC} from FLUSH; rom_size=3.
- Hold mem_ack off for 10 cycles while 1 extra byte arrives -> ioctl_wait=1 throughout; skid byte is written afterwards; no data lost; ovf=0.
- Download of 8192+512 bytes -> rom_size=25'd8704, rom_hdr=1; a 8192-byte download gives rom_hdr=0.
- Download with ioctl_index=1 -> no mem_req, rom_ready and rom_size unchanged from the previous load.
- reset_n=0 while mem_req=1 -> next cycle mem_req=0, ioctl_wait=0, rom_ready=0, state IDLE; a fresh download then completes normally.
